// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with majority-vote bit sampling feeding a
// small receive FIFO that stores per-frame frame/parity error flags alongside the data.
module uart_rx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx,
   input  logic [31:0]                   baud_divisor,
   input  logic                          parity_en,
   input  logic                          parity_odd,
   input  logic                          stop2,
   input  logic                          data_ready,
   input  logic                          clr_overrun,
   output logic [7:0]                    data_out,
   output logic                          data_valid,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = DATA_BITS + 2;
   localparam logic [SW-1:0] MID_LO = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] MID    = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] MID_HI = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [SW-1:0] LAST   = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

   state_t                      state_q, state_d;
   logic                        rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
   logic [31:0]                 tick_cnt_q, tick_cnt_d, div;
   logic [SW-1:0]               samp_q, samp_d;
   logic [BW-1:0]               bit_q, bit_d;
   logic [1:0]                  hist_q, hist_d;
   logic [DATA_BITS-1:0]        shift_q, shift_d;
   logic                        ferr_q, ferr_d, perr_q, perr_d;
   logic                        pen_q, pen_d, podd_q, podd_d, stop2_q, stop2_d;
   logic                        push_q, push_d;
   logic [FIFO_DEPTH-1:0][EW-1:0] mem_q, mem_d;
   logic [AW-1:0]               wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]               count_q, count_d;
   logic                        overrun_q, overrun_d;
   logic                        tick, maj, at_maj, at_end, pop, wr_en, ovf;
   logic [EW-1:0]               head;

   always_comb begin
      rx_meta_d  = rx;
      rx_sync_d  = rx_meta_q;
      div        = (baud_divisor == 32'd0) ? 32'd1 : baud_divisor;
      tick       = tick_cnt_q >= div - 32'd1;
      tick_cnt_d = tick ? 32'd0 : tick_cnt_q + 32'd1;
      maj        = (hist_q[0] & hist_q[1]) | (rx_sync_q & (hist_q[0] | hist_q[1]));
      at_maj     = tick && samp_q == MID_HI;
      at_end     = tick && samp_q == LAST;
      state_d    = state_q;
      samp_d     = samp_q;
      bit_d      = bit_q;
      hist_d     = hist_q;
      shift_d    = shift_q;
      ferr_d     = ferr_q;
      perr_d     = perr_q;
      pen_d      = pen_q;
      podd_d     = podd_q;
      stop2_d    = stop2_q;
      push_d     = 1'b0;
      if (state_q != IDLE && tick) begin
         samp_d = (samp_q == LAST) ? '0 : samp_q + 1'b1;
         if (samp_q == MID_LO || samp_q == MID) hist_d = {hist_q[0], rx_sync_q};
      end
      case (state_q)
         IDLE: if (tick && !rx_sync_q) begin
            state_d = START;
            samp_d  = '0;
            bit_d   = '0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
            pen_d   = parity_en;
            podd_d  = parity_odd;
            stop2_d = stop2;
         end
         START: state_d = (at_maj && maj) ? IDLE : at_end ? DATA : START;
         DATA: begin
            if (at_maj) shift_d[bit_q] = maj;
            if (at_end) begin
               bit_d   = bit_q + 1'b1;
               state_d = (bit_q != LAST_BIT) ? DATA : pen_q ? PARITY : STOP1;
            end
         end
         PARITY: begin
            if (at_maj) perr_d = (^shift_q ^ maj) != podd_q;
            if (at_end) state_d = STOP1;
         end
         STOP1: begin
            if (at_maj) ferr_d = ferr_q | ~maj;
            push_d  = at_maj && !stop2_q;
            state_d = (at_maj && !stop2_q) ? IDLE : at_end ? STOP2 : STOP1;
         end
         STOP2: begin
            if (at_maj) ferr_d = ferr_q | ~maj;
            push_d  = at_maj;
            state_d = at_maj ? IDLE : STOP2;
         end
         default: state_d = IDLE;
      endcase
   end

   // A push into a full FIFO still lands when the head is popped in the same cycle.
   always_comb begin
      data_valid = count_q != '0;
      pop        = data_valid & data_ready;
      wr_en      = push_q & (count_q != FULL | pop);
      ovf        = push_q & count_q == FULL & ~pop;
      mem_d      = mem_q;
      if (wr_en) mem_d[wr_q] = {perr_q, ferr_q, shift_q};
      wr_d       = wr_q + AW'(wr_en);
      rd_d       = rd_q + AW'(pop);
      count_d    = count_q + CW'(wr_en) - CW'(pop);
      overrun_d  = ovf | (overrun_q & ~clr_overrun);
      head       = mem_q[rd_q];
      data_out   = 8'(head[DATA_BITS-1:0]);
      frame_err  = head[DATA_BITS];
      parity_err = head[DATA_BITS+1];
      overrun    = overrun_q;
      fifo_count = count_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         tick_cnt_q <= '0;
         samp_q     <= '0;
         bit_q      <= '0;
         hist_q     <= '0;
         shift_q    <= '0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
         pen_q      <= 1'b0;
         podd_q     <= 1'b0;
         stop2_q    <= 1'b0;
         push_q     <= 1'b0;
         mem_q      <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         count_q    <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_meta_q  <= rx_meta_d;
         rx_sync_q  <= rx_sync_d;
         tick_cnt_q <= tick_cnt_d;
         samp_q     <= samp_d;
         bit_q      <= bit_d;
         hist_q     <= hist_d;
         shift_q    <= shift_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
         pen_q      <= pen_d;
         podd_q     <= podd_d;
         stop2_q    <= stop2_d;
         push_q     <= push_d;
         mem_q      <= mem_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         count_q    <= count_d;
         overrun_q  <= overrun_d;
      end
   end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo; an 8-bit instance covers the main
// receive/FIFO behaviour and a 5-bit instance covers short frames with two stop bits.
module tb_uart_rx_fifo;
   localparam int BIT = 64;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   logic        clk = 1'b0, rst = 1'b0, rx = 1'b1, rx5 = 1'b1;
   logic [31:0] baud_divisor = 32'd4;
   logic        parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0, clr_overrun = 1'b0;
   logic        data_ready = 1'b0, data_ready5 = 1'b0;
   logic [7:0]  data_out, data_out5;
   logic        data_valid, data_valid5, frame_err, frame_err5, parity_err, parity_err5;
   logic        overrun, overrun5;
   logic [3:0]  fifo_count, fifo_count5;
   exp_t        q[$], q5[$];
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   uart_rx_fifo u_dut (
      .clk(clk), .rst(rst), .rx(rx), .baud_divisor(baud_divisor), .parity_en(parity_en),
      .parity_odd(parity_odd), .stop2(stop2), .data_ready(data_ready), .clr_overrun(clr_overrun),
      .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
      .parity_err(parity_err), .overrun(overrun), .fifo_count(fifo_count)
   );

   uart_rx_fifo #(.DATA_BITS(5)) u_dut5 (
      .clk(clk), .rst(rst), .rx(rx5), .baud_divisor(baud_divisor), .parity_en(parity_en),
      .parity_odd(parity_odd), .stop2(stop2), .data_ready(data_ready5), .clr_overrun(clr_overrun),
      .data_out(data_out5), .data_valid(data_valid5), .frame_err(frame_err5),
      .parity_err(parity_err5), .overrun(overrun5), .fifo_count(fifo_count5)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic drive(input bit sel, input logic v, input int n);
      if (sel) rx5 = v;
      else rx = v;
      repeat (n) @(posedge clk);
   endtask

   task automatic send(input bit sel, input int nb, input logic [7:0] d, input bit pen,
                       input bit pbit, input int ns, input bit sv, input bit keep);
      exp_t e;
      logic [7:0] m;
      m    = 8'hFF >> (8 - nb);
      e.d  = d & m;
      e.fe = !sv;
      e.pe = pen && ((^(d & m) ^ pbit) != parity_odd);
      if (keep) begin
         if (sel) q5.push_back(e);
         else q.push_back(e);
      end
      drive(sel, 1'b0, BIT);
      for (int i = 0; i < nb; i++) drive(sel, d[i], BIT);
      if (pen) drive(sel, pbit, BIT);
      for (int i = 0; i < ns; i++) drive(sel, sv, BIT);
      drive(sel, 1'b1, 0);
   endtask

   task automatic drain(input bit sel);
      exp_t e;
      bit   stop;
      stop = 0;
      while (!stop && (sel ? q5.size() : q.size()) != 0) begin
         @(negedge clk);
         if (!(sel ? data_valid5 : data_valid)) begin
            check("drain_valid", 0, 1);
            stop = 1;
         end else begin
            e = sel ? q5.pop_front() : q.pop_front();
            check("data", sel ? data_out5 : data_out, e.d);
            check("frame_err", sel ? frame_err5 : frame_err, e.fe);
            check("parity_err", sel ? parity_err5 : parity_err, e.pe);
            if (sel) data_ready5 = 1'b1;
            else data_ready = 1'b1;
            @(negedge clk);
            data_ready  = 1'b0;
            data_ready5 = 1'b0;
         end
      end
      if (sel) q5.delete();
      else q.delete();
      @(negedge clk);
      check("count_after_drain", sel ? fifo_count5 : fifo_count, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_valid", data_valid, 0);
      check("rst_count", fifo_count, 0);
      check("rst_data", data_out, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_perr", parity_err, 0);
      check("rst_overrun", overrun, 0);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      // empty pop attempt must not disturb the count
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      check("empty_pop_count", fifo_count, 0);

      send(0, 8, 8'hA5, 0, 0, 1, 1, 1);
      @(negedge clk);
      check("a5_valid", data_valid, 1);
      check("a5_count", fifo_count, 1);
      drain(0);

      parity_en  = 1'b1;
      parity_odd = 1'b0;
      send(0, 8, 8'h07, 1, 0, 1, 1, 1);
      parity_odd = 1'b1;
      send(0, 8, 8'h07, 1, 0, 1, 1, 1);
      @(negedge clk);
      check("parity_count", fifo_count, 2);
      drain(0);
      parity_en  = 1'b0;
      parity_odd = 1'b0;

      send(0, 8, 8'h3C, 0, 0, 1, 0, 1);
      drive(0, 1'b1, 2 * BIT);
      send(0, 8, 8'h55, 0, 0, 1, 1, 1);
      drain(0);

      for (int i = 0; i < 9; i++) send(0, 8, 8'(i * 37 + 3), 0, 0, 1, 1, i < 8);
      @(negedge clk);
      check("ovf_count", fifo_count, 8);
      check("ovf_flag", overrun, 1);
      drain(0);
      check("ovf_sticky", overrun, 1);
      clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
      check("ovf_cleared", overrun, 0);

      drive(0, 1'b0, 12);
      drive(0, 1'b1, 2 * BIT);
      @(negedge clk);
      check("glitch_count", fifo_count, 0);
      check("glitch_valid", data_valid, 0);

      send(0, 8, 8'h11, 0, 0, 1, 1, 0);
      @(negedge clk);
      check("pre_rst_count", fifo_count, 1);
      drive(0, 1'b0, BIT);
      for (int i = 0; i < 4; i++) drive(0, 1'(i % 2), BIT);
      @(negedge clk);
      rst = 1'b0;
      rx  = 1'b1;
      repeat (4) @(negedge clk);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_valid", data_valid, 0);
      rst = 1'b1;
      drive(0, 1'b1, BIT);
      send(0, 8, 8'h9C, 0, 0, 1, 1, 1);
      drain(0);

      stop2 = 1'b1;
      send(1, 5, 8'h1F, 0, 0, 2, 1, 1);
      @(negedge clk);
      check("d5_count", fifo_count5, 1);
      check("d5_data", data_out5, 8'h1F);
      send(1, 5, 8'h0A, 0, 0, 2, 1, 1);
      send(1, 5, 8'h15, 0, 0, 2, 1, 1);
      send(1, 5, 8'h13, 0, 0, 2, 1, 1);
      @(negedge clk);
      check("d5_b2b_count", fifo_count5, 4);
      drain(1);
      check("main_idle_count", fifo_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8, frame data width; legal range 5..8.
REQ-002 Parameter OVERSAMPLE, default 16, sample ticks per bit; even, at least 8.
REQ-003 Parameter FIFO_DEPTH, default 8, receive FIFO entries; power of 2, at least 2.
REQ-004 clk  in  1  single clock; all state on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset (assert at 0, release synchronously to clk).
REQ-006 rx  in  1  serial line; idles high; asynchronous to clk.
REQ-007 baud_divisor  in  32  clk cycles per sample tick; 0 is treated as 1.
REQ-008 parity_en  in  1  1 = a parity bit follows the data bits.
REQ-009 parity_odd  in  1  1 = odd parity, 0 = even parity; ignored when parity_en=0.
REQ-010 stop2  in  1  1 = two stop bits, 0 = one stop bit.
REQ-011 data_ready  in  1  consumer accepts the head entry.
REQ-012 clr_overrun  in  1  one-cycle pulse that clears overrun.
REQ-013 data_out  out  8  head FIFO data; bits above DATA_BITS-1 read 0.
REQ-014 data_valid  out  1  FIFO not empty.
REQ-015 frame_err  out  1  error flag stored with the head entry: stop bit sampled 0.
REQ-016 parity_err  out  1  error flag stored with the head entry: parity mismatch.
REQ-017 overrun  out  1  sticky: a frame was dropped because the FIFO was full.
REQ-018 fifo_count  out  $clog2(FIFO_DEPTH)+1  number of stored entries.

Function
REQ-019 rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; all rx references below use the synchronized value.
REQ-020 Tick counter SHALL count 0..max(baud_divisor,1)-1, assert tick for one clk at the terminal count, and wrap to 0; it SHALL free-run in all states.
REQ-021 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-022 IDLE: a synchronized rx value of 0 on a tick SHALL move the FSM to START with the sample counter set to 0.
REQ-023 Each bit lasts OVERSAMPLE ticks; the bit value SHALL be the majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
REQ-024 START: a majority value of 1 SHALL be treated as a glitch and return the FSM to IDLE with no push and no error.
REQ-025 DATA: DATA_BITS bits SHALL be received LSB first, then the FSM SHALL go to PARITY if parity_en=1, else to STOP1.
REQ-026 PARITY: parity_err SHALL be set when XOR(data bits, parity bit) differs from parity_odd.
REQ-027 STOP1/STOP2: a majority value of 0 in any stop bit SHALL set frame_err.
REQ-028 After the majority sample of the final stop bit, the frame SHALL be pushed on the next clk and the FSM SHALL go to IDLE without waiting out the rest of the bit, so back-to-back frames are received.
REQ-029 parity_en, parity_odd and stop2 SHALL be sampled on leaving IDLE and held constant for the whole frame.
REQ-030 FIFO: data_valid SHALL equal (fifo_count != 0); a pop occurs when data_valid=1 and data_ready=1; data_out, frame_err and parity_err SHALL show the head entry combinationally from storage.
REQ-031 Push when full with no pop in the same cycle SHALL drop the new frame and set overrun.
REQ-032 Push and pop in the same cycle SHALL both take effect, including when full, with no overrun.
REQ-033 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-034 clr_overrun SHALL clear overrun on the next clk; if an overflow occurs in the same cycle, overrun SHALL stay set (set wins).
REQ-035 data_ready while empty SHALL have no effect.

Reset
REQ-036 While rst=0: FSM=IDLE, counters=0, pointers=0, fifo_count=0, data_valid=0, data_out=0, frame_err=0, parity_err=0, overrun=0, synchronizer=1.
REQ-037 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL wait for a new start bit.

Verification
REQ-038 baud_divisor=4, OVERSAMPLE=16, 8N1, send 0xA5 -> within 2 ticks after the stop-bit sample: data_valid=1, data_out=0xA5, no error flags, fifo_count=1.
REQ-039 8E1 with parity bit 0 on 0x07 -> parity_err=1 with data_out=0x07; 8O1 with parity bit 0 on 0x07 -> parity_err=0.
REQ-040 Stop bit driven 0 on 0x3C -> frame_err=1, data 0x3C stored; the next frame 0x55 is received clean.
REQ-041 9 frames sent with data_ready=0, FIFO_DEPTH=8 -> fifo_count=8, overrun=1, first 8 bytes read in order; clr_overrun clears overrun.
REQ-042 Start-bit glitch of 3 ticks low -> no push, FSM back in IDLE; rst pulsed mid-byte -> fifo_count=0, the next full frame is received correctly.
REQ-043 DATA_BITS=5 with 2 stop bits, send 0x1F -> data_out=0x1F with bits 7:5 = 0; back-to-back frames with no idle gap all received.
